// File: rtl/ge_pkg.sv
// Shared definitions for the GE grading chain: FSM states and default grading constants.
// Stage1/stage2 benches reuse the same defaults.
package ge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    JUDGE   = 2'd2,
    HOLD    = 2'd3
  } ge_state_e;

  localparam int unsigned GE_ROUNDS    = 4;
  localparam int unsigned GE_PASS_MIN  = 3;
  localparam int unsigned GE_BONUS_MIN = 6;

endpackage

// File: rtl/stage3_verdict.sv
// Verdict rule: pass on enough passes, or one short with enough bonus; grade = min(score/2, 7).
// Purely combinational, no state and no backpressure.
module stage3_verdict
  import ge_pkg::*;
#(
  parameter int unsigned ROUNDS    = GE_ROUNDS,
  parameter int unsigned PASS_MIN  = GE_PASS_MIN,
  parameter int unsigned BONUS_MIN = GE_BONUS_MIN,
  localparam int unsigned CW = $clog2(ROUNDS + 1),
  localparam int unsigned BW = $clog2(3 * ROUNDS + 1)
) (
  input  logic [CW-1:0] pass_cnt,
  input  logic [BW-1:0] bonus_sum,
  output logic          pass3,
  output logic [2:0]    grade3
);

  localparam int unsigned SW = $clog2(5 * ROUNDS + 1);

  logic [SW-1:0] score;
  logic [SW-1:0] half;

  always_comb begin
    score  = (SW'(pass_cnt) << 1) + SW'(bonus_sum);
    half   = score >> 1;
    pass3  = (32'(pass_cnt) >= PASS_MIN) ||
             ((32'(pass_cnt) == PASS_MIN - 1) && (32'(bonus_sum) >= BONUS_MIN));
    grade3 = 3'd0;
    if (pass3) begin
      grade3 = (half > SW'(7)) ? 3'd7 : half[2:0];
    end
  end

endmodule

// File: rtl/stage3_judge.sv
// Stage3: collects ROUNDS stage2 results per student and issues one verdict; final beat to out_valid is 2 edges.
// in_ready drops from JUDGE until the verdict is accepted; the verdict is held while out_ready is low.
module stage3_judge
  import ge_pkg::*;
#(
  parameter int unsigned ROUNDS    = GE_ROUNDS,
  parameter int unsigned PASS_MIN  = GE_PASS_MIN,
  parameter int unsigned BONUS_MIN = GE_BONUS_MIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       pass2,
  input  logic [1:0] bonus2,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pass3,
  output logic [2:0] grade3,
  output logic [7:0] stu_cnt
);

  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam int unsigned BW = $clog2(3 * ROUNDS + 1);
  localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);

  ge_state_e     state_q, state_d;
  logic [CW-1:0] round_cnt_q, round_cnt_d;
  logic [CW-1:0] pass_cnt_q, pass_cnt_d;
  logic [BW-1:0] bonus_sum_q, bonus_sum_d;
  logic          out_valid_q, out_valid_d;
  logic          pass3_q, pass3_d;
  logic [2:0]    grade3_q, grade3_d;
  logic [7:0]    stu_cnt_q, stu_cnt_d;

  logic          beat;
  logic          v_pass3;
  logic [2:0]    v_grade3;

  stage3_verdict #(
    .ROUNDS   (ROUNDS),
    .PASS_MIN (PASS_MIN),
    .BONUS_MIN(BONUS_MIN)
  ) u_verdict (
    .pass_cnt (pass_cnt_q),
    .bonus_sum(bonus_sum_q),
    .pass3    (v_pass3),
    .grade3   (v_grade3)
  );

  assign in_ready = (state_q == IDLE) || (state_q == COLLECT);
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    bonus_sum_d = bonus_sum_q;
    out_valid_d = out_valid_q;
    pass3_d     = pass3_q;
    grade3_d    = grade3_q;
    stu_cnt_d   = stu_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (beat) begin
          pass_cnt_d  = CW'(pass2);
          bonus_sum_d = BW'(bonus2);
          round_cnt_d = CW'(1);
          state_d     = (ROUNDS == 1) ? JUDGE : COLLECT;
        end
      end
      COLLECT: begin
        // flush wins over a beat arriving in the same cycle; that beat is lost
        if (flush) begin
          pass_cnt_d  = '0;
          bonus_sum_d = '0;
          round_cnt_d = '0;
          state_d     = IDLE;
        end else if (beat) begin
          pass_cnt_d  = pass_cnt_q + CW'(pass2);
          bonus_sum_d = bonus_sum_q + BW'(bonus2);
          round_cnt_d = round_cnt_q + CW'(1);
          if (round_cnt_d == ROUNDS_C) begin
            state_d = JUDGE;
          end
        end
      end
      JUDGE: begin
        pass3_d     = v_pass3;
        grade3_d    = v_grade3;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pass_cnt_d  = '0;
          bonus_sum_d = '0;
          round_cnt_d = '0;
          stu_cnt_d   = stu_cnt_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_cnt_q <= '0;
      pass_cnt_q  <= '0;
      bonus_sum_q <= '0;
      out_valid_q <= 1'b0;
      pass3_q     <= 1'b0;
      grade3_q    <= 3'd0;
      stu_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      bonus_sum_q <= bonus_sum_d;
      out_valid_q <= out_valid_d;
      pass3_q     <= pass3_d;
      grade3_q    <= grade3_d;
      stu_cnt_q   <= stu_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pass3     = pass3_q;
  assign grade3    = grade3_q;
  assign stu_cnt   = stu_cnt_q;

endmodule

// File: tb/tb_stage3_judge.sv
// Bench for stage3_judge: scoreboard of expected verdicts, popped on each out_valid/out_ready handshake.
module tb_stage3_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       pass2;
  logic [1:0] bonus2;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic       pass3;
  logic [2:0] grade3;
  logic [7:0] stu_cnt;

  logic [2:0] v_pc;
  logic [3:0] v_bs;
  logic       v_pass3;
  logic [2:0] v_grade3;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [3:0] sb[$];
  logic [3:0] sb_exp;
  logic [7:0] exp_stu = 8'd0;
  bit         done6 = 1'b0;

  always #5 clk = ~clk;

  stage3_judge dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pass2    (pass2),
    .bonus2   (bonus2),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pass3    (pass3),
    .grade3   (grade3),
    .stu_cnt  (stu_cnt)
  );

  stage3_verdict u_vrf (
    .pass_cnt (v_pc),
    .bonus_sum(v_bs),
    .pass3    (v_pass3),
    .grade3   (v_grade3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference rule with PASS_MIN=3, BONUS_MIN=6: returns {pass, grade}
  function automatic logic [3:0] model(input int pc, input int bs);
    bit p;
    int g;
    p = (pc >= 3) || (pc == 2 && bs >= 6);
    g = (2 * pc + bs) / 2;
    if (g > 7) g = 7;
    if (!p) g = 0;
    return {p, 3'(g)};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        sb_exp = sb.pop_front();
        chk("verdict_pass3", int'(pass3), int'(sb_exp[3]));
        chk("verdict_grade3", int'(grade3), int'(sb_exp[2:0]));
      end
      exp_stu = exp_stu + 8'd1;
    end
  end

  // Starts and ends just after a rising edge
  task automatic beat(input logic p, input logic [1:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    pass2    = p;
    bonus2   = b;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_student(input logic [3:0] p, input logic [7:0] b, input bit gaps);
    int pc;
    int bs;
    pc = 0;
    bs = 0;
    for (int i = 0; i < 4; i++) begin
      pc += int'(p[i]);
      bs += int'(b[i*2 +: 2]);
    end
    sb.push_back(model(pc, bs));
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      beat(p[i], b[i*2 +: 2]);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0 || out_valid) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; pass2 = 1'b0; bonus2 = 2'd0;
    flush = 1'b0; out_ready = 1'b0;
    v_pc = '0; v_bs = '0;

    for (int pc = 0; pc <= 4; pc++) begin
      for (int bs = 0; bs <= 12; bs++) begin
        v_pc = 3'(pc);
        v_bs = 4'(bs);
        #1;
        chk($sformatf("vrf_pass_%0d_%0d", pc, bs), int'(v_pass3), int'(model(pc, bs) >> 3));
        chk($sformatf("vrf_grade_%0d_%0d", pc, bs), int'(v_grade3), int'(model(pc, bs) & 7));
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pass3", int'(pass3), 0);
    chk("rst_grade3", int'(grade3), 0);
    chk("rst_stu_cnt", int'(stu_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Latency and saturated grade
    out_ready = 1'b1;
    run_student(4'b1111, 8'hFF, 1'b0);
    chk("t1_judge_ov", int'(out_valid), 0);
    chk("t1_judge_rdy", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("t1_ov", int'(out_valid), 1);
    @(posedge clk); #1;
    chk("t1_ov_drop", int'(out_valid), 0);
    chk("t1_stu", int'(stu_cnt), 1);

    // Bonus rescue boundary: sum 5 fails, sum 6 passes
    run_student(4'b0011, {2'd0, 2'd1, 2'd2, 2'd2}, 1'b0);
    run_student(4'b0011, {2'd1, 2'd1, 2'd2, 2'd2}, 1'b0);
    wait_drain();
    chk("t2_stu", int'(stu_cnt), int'(exp_stu));

    // Held verdict with in_valid pushing during JUDGE/HOLD
    out_ready = 1'b0;
    run_student(4'b1111, 8'h00, 1'b0);
    in_valid = 1'b1; pass2 = 1'b1; bonus2 = 2'd3;
    repeat (5) begin
      @(negedge clk);
      chk("t3_in_ready", int'(in_ready), 0);
    end
    chk("t3_ov", int'(out_valid), 1);
    chk("t3_pass3", int'(pass3), 1);
    chk("t3_grade3", int'(grade3), 4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    run_student(4'b1100, 8'hFF, 1'b0);
    wait_drain();
    chk("t3_stu", int'(stu_cnt), int'(exp_stu));

    // Flush discards the partial student and the coincident beat
    beat(1'b1, 2'd3);
    beat(1'b1, 2'd3);
    in_valid = 1'b1; pass2 = 1'b1; bonus2 = 2'd3; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_in_ready", int'(in_ready), 1);
    out_ready = 1'b0;
    run_student(4'b0000, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("t4_ov", int'(out_valid), 1);
    chk("t4_stu_hold", int'(stu_cnt), int'(exp_stu));
    out_ready = 1'b1;
    wait_drain();
    chk("t4_stu", int'(stu_cnt), int'(exp_stu));

    // Reset while holding a verdict
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b1, 2'd3);
    @(posedge clk); #1;
    chk("t5_ov_before", int'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stu = 8'd0;
    chk("t5_ov", int'(out_valid), 0);
    chk("t5_stu", int'(stu_cnt), 0);
    chk("t5_in_ready", int'(in_ready), 1);
    chk("t5_pass3", int'(pass3), 0);

    // 256 random students with random gaps and consumer stalls
    fork
      begin
        for (int s = 0; s < 256; s++) begin
          run_student(4'($urandom), 8'($urandom), 1'b1);
        end
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("t6_stu_model", int'(stu_cnt), int'(exp_stu));
    chk("t6_wrap", int'(stu_cnt), 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
